flash_req_arbiter: RTL
======================

FLASH_REQ_ARBITER -- requirements
Module: flash_req_arbiter

Interface
REQ-001 SHALL have parameter PRESCALE, default 5, meaning the LLC completion-sampling period in ACLK cycles (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum WAIT duration before abort (legal range 1..2^20-1).
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port ARESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester request valid (bit 0 fetch, bit 1 data).
REQ-006 SHALL have port req_ready, output, 2 bits: per-requester request accept.
REQ-007 SHALL have port req_op, input, 4 bits: 2 bits per port; 00 read, 01 write, 10 erase dir0, 11 erase dir1.
REQ-008 SHALL have port req_addr, input, 48 bits: 24-bit flash address per port.
REQ-009 SHALL have port req_wdata, input, 64 bits: 32-bit write word per port.
REQ-010 SHALL have port rsp_valid, output, 2 bits: per-port response valid.
REQ-011 SHALL have port rsp_ready, input, 2 bits: per-port response accept.
REQ-012 SHALL have port rsp_data, output, 32 bits: read word, shared, qualified by rsp_valid.
REQ-013 SHALL have port rsp_err, output, 1 bit: timeout error flag, qualified by rsp_valid.
REQ-014 SHALL have LLC-side ports llc_start (out, 1), llc_address (out, 24), llc_word (out, 32), llc_dir (out, 1), llc_erase (out, 1): the command to the low-level QSPI controller.
REQ-015 SHALL have LLC-side ports llc_rdata (in, 32), llc_valid (in, 1), llc_busy (in, 1): the completion and status from the low-level QSPI controller.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE with llc_busy=0 and any req_valid set, SHALL assert req_ready for exactly one winner combinationally, latch its op/addr/wdata and grant index, and enter WAIT next cycle.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the port not last served wins; after reset, port 0 wins.
REQ-019 In IDLE with llc_busy=1, req_ready SHALL be 0.
REQ-020 In IDLE, a single valid port SHALL win regardless of the pointer.
REQ-021 In WAIT, llc_start SHALL be 1 and llc_address/llc_word SHALL hold the latched values; llc_start rises in the cycle after acceptance.
REQ-022 Op mapping: read gives dir=0, erase=0; write gives dir=1, erase=0; erase dir0 gives dir=0, erase=1; erase dir1 gives dir=1, erase=1.
REQ-023 A prescale counter SHALL load PRESCALE-1 on WAIT entry, decrement each cycle, sample llc_valid only at 0, and reload on a miss.
REQ-024 A sampled llc_valid=1 SHALL capture llc_rdata (reads) or 0 (write/erase) into rsp_data, drop llc_start, and enter RESP.
REQ-025 In RESP, rsp_valid[grant] SHALL be 1 and the other bit 0; on rsp_ready[grant], SHALL go to IDLE and set the pointer to grant.
REQ-026 No request SHALL be accepted in WAIT or RESP, and req_valid in those states is ignored.

Reset
REQ-027 While ARESETn=0, SHALL be in IDLE, with all outputs 0, counters 0, latched fields 0, and the pointer favouring port 0.
REQ-028 Reset mid-WAIT SHALL drop llc_start immediately (asynchronously), without producing a response.

Configuration
REQ-029 Macro FLASH_ARB_TIMEOUT_EN defined: SHALL count WAIT cycles and, on reaching TIMEOUT_CYCLES without a sampled llc_valid, drop llc_start and enter RESP with rsp_err=1 and rsp_data=0.
REQ-030 Macro FLASH_ARB_TIMEOUT_EN undefined: SHALL omit the timeout counter, tie rsp_err to 0, and wait indefinitely.

Structure
REQ-031 Package flash_arb_pkg SHALL hold the state enum, op encodings, and the PRESCALE/TIMEOUT defaults.
REQ-032 The 2-way round-robin selection SHALL be sub-module flash_rr_arbiter.

Verification
REQ-033 Port0 read at 0x000100, LLC returns 0xDEADBEEF -> rsp_valid=01 and rsp_data=0xDEADBEEF; llc_start high from cycle after accept until the sampled llc_valid.
REQ-034 Both ports valid in the same cycle after reset -> port0 served first, port1 second; repeat -> port1 then port0.
REQ-035 Port1 erase dir1 at 0x010000 -> llc_erase=1 and llc_dir=1; response rsp_valid=10 with rsp_data=0.
REQ-036 llc_valid pulsed on a non-sampling cycle (PRESCALE=5) -> ignored; held through counter=0 -> completes.
REQ-037 With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, llc_valid never asserted -> rsp_err=1 at cycle 100 and llc_start=0.
REQ-038 ARESETn asserted mid-WAIT -> llc_start=0 at once; after release, IDLE and a new request is accepted.

Source files
------------

// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flash_arb_pkg
// Brief   : State enum, op encodings and default timing for flash_req_arbiter
// Revision: 1.0
// ============================================================================
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_ERASE0 = 2'b10;
    localparam logic [1:0] OP_ERASE1 = 2'b11;

    localparam int unsigned PRESCALE_DEF = 5;
    localparam int unsigned TIMEOUT_DEF  = 65535;

    function automatic logic op_dir(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_ERASE1);
    endfunction

    function automatic logic op_erase(input logic [1:0] op);
        return (op == OP_ERASE0) || (op == OP_ERASE1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : flash_rr_arbiter
// Brief   : 2-way round-robin pick; on a tie the port not last served wins
// Revision: 1.0
// ============================================================================
module flash_rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    always_comb begin
        if (req_i == 2'b11) begin
            idx_o = ~last_i;
        end else begin
            idx_o = req_i[1];
        end
        gnt_o = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : flash_req_arbiter
// Brief   : Two-port round-robin front end for a low-level QSPI flash controller.
//           Define FLASH_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
// Revision: 1.0
// ============================================================================
module flash_req_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned PRESCALE       = PRESCALE_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [47:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        llc_start,
    output logic [23:0] llc_address,
    output logic [31:0] llc_word,
    output logic        llc_dir,
    output logic        llc_erase,
    input  logic [31:0] llc_rdata,
    input  logic        llc_valid,
    input  logic        llc_busy
);

    localparam logic [7:0] PRE_RELOAD = 8'(PRESCALE - 1);

    arb_state_e  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  pre_q, pre_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  arb_gnt;
    logic        arb_idx;
    logic        accept;
    logic        sample;
    logic        timeout;

    flash_rr_arbiter u_rr (
        .req_i  (req_valid),
        .last_i (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign accept = ARESETn && (state_q == IDLE) && !llc_busy && (req_valid != 2'b00);
    assign sample = (state_q == WAIT) && (pre_q == 8'd0) && llc_valid;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    // A completion sampled on the last allowed cycle still wins over the abort.
    assign timeout = (state_q == WAIT) && (tmo_q == TMO_LAST) && !sample;

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (accept) begin
            tmo_d = '0;
            err_d = 1'b0;
        end else if (state_q == WAIT) begin
            tmo_d = tmo_q + 20'd1;
            if (timeout) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (sample || timeout) state_d = RESP;
            RESP:    if (rsp_ready[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (ARESETn && (state_q == IDLE) && !llc_busy) ? arb_gnt : 2'b00;
        llc_start = (state_q == WAIT);
        rsp_valid = 2'b00;
        if (state_q == RESP) begin
            rsp_valid = gnt_q ? 2'b10 : 2'b01;
        end
        llc_address = addr_q;
        llc_word    = wdata_q;
        llc_dir     = op_dir(op_q);
        llc_erase   = op_erase(op_q);
        rsp_data    = rdata_q;
    end

    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pre_d   = pre_q;
        rdata_d = rdata_q;
        if (accept) begin
            gnt_d   = arb_idx;
            op_d    = arb_idx ? req_op[3:2]     : req_op[1:0];
            addr_d  = arb_idx ? req_addr[47:24] : req_addr[23:0];
            wdata_d = arb_idx ? req_wdata[63:32] : req_wdata[31:0];
            pre_d   = PRE_RELOAD;
        end else if (state_q == WAIT) begin
            pre_d = (pre_q == 8'd0) ? PRE_RELOAD : pre_q - 8'd1;
            if (sample) begin
                rdata_d = (op_q == OP_READ) ? llc_rdata : 32'd0;
            end else if (timeout) begin
                rdata_d = 32'd0;
            end
        end else if ((state_q == RESP) && rsp_ready[gnt_q]) begin
            ptr_d = gnt_q;
        end
    end

    // Pointer holds the last-served port; resetting it to 1 lets port 0 win first.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q   <= 1'b1;
            gnt_q   <= 1'b0;
            op_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            pre_q   <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pre_q   <= pre_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
`default_nettype wire
